sram_uart_transmit_interface: RTL

// - Reads a block of 16-bit words from external SRAM and streams them out on the UART TX pin, high byte first, then low byte.
// - Return path for data loaded into SRAM by the UART receive side; dumps decoded image data or memory contents to the host.
// - Sits beside the SRAM controller; owns the SRAM address bus only while Busy is high. The top level muxes the address bus.

---
 rtl/sram_uart_transmit_interface_pkg.sv | 25 ++
 rtl/sram_uart_transmit_interface_tx.sv | 97 +++++++++
 rtl/sram_uart_transmit_interface.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sram_uart_transmit_interface_pkg.sv
// Shared state types for the SRAM-to-UART transmit path and its serial transmitter.
package sram_uart_transmit_interface_pkg;

  typedef enum logic [2:0] {
    S_UT_IDLE,
    S_UT_ISSUE_READ,
    S_UT_WAIT_READ,
    S_UT_SEND_HIGH,
    S_UT_WAIT_HIGH,
    S_UT_SEND_LOW,
    S_UT_WAIT_LOW,
    S_UT_DONE
  } SRAM_UART_state_type;

  typedef enum logic [1:0] {
    S_TX_IDLE,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP
  } TX_state_type;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;

endpackage

// File: rtl/sram_uart_transmit_interface_tx.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
import sram_uart_transmit_interface_pkg::*;

module UART_transmit_controller #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       Clock_50,
  input  logic       Resetn,
  input  logic       Initialize,
  input  logic       Load,
  input  logic [7:0] TX_data,
  output logic       Busy,
  output logic       UART_TX_O
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  TX_state_type      state_q;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              busy_q;
  logic              bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    baud_d = baud_q + BAUD_W'(1);
    if (bit_end) baud_d = '0;
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else if (Initialize) begin
      state_q <= S_TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_TX_IDLE: begin
          if (Load) begin
            shift_q <= TX_data;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            baud_q  <= '0;
            state_q <= S_TX_START;
          end
        end
        S_TX_START: begin
          baud_q <= baud_d;
          if (bit_end) begin
            tx_q    <= shift_q[0];
            bit_q   <= '0;
            state_q <= S_TX_DATA;
          end
        end
        S_TX_DATA: begin
          baud_q <= baud_d;
          if (bit_end) begin
            if (bit_q == 4'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_TX_STOP;
            end else begin
              // Next bit is driven straight from shift_q[1] so it lands in the same edge as the shift.
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 4'd1;
            end
          end
        end
        S_TX_STOP: begin
          baud_q <= baud_d;
          if (bit_end) begin
            busy_q  <= 1'b0;
            state_q <= S_TX_IDLE;
          end
        end
        default: state_q <= S_TX_IDLE;
      endcase
    end
  end

  assign Busy      = busy_q;
  assign UART_TX_O = tx_q;

endmodule

// File: rtl/sram_uart_transmit_interface.sv
// Streams a block of SRAM words out of the UART, high byte then low byte, stopping at the top of memory.
import sram_uart_transmit_interface_pkg::*;

module sram_uart_transmit_interface #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Initialize,
  input  logic        Enable,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned LAT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);

  SRAM_UART_state_type    state_q;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic [SRAM_ADDR_W-1:0] words_left_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic [SRAM_DATA_W-1:0] word_buf_q;
  logic [LAT_W-1:0]       lat_q;
  logic                   seen_rise_q;
  logic                   busy_q;
  logic                   done_q;

  logic       tx_load;
  logic [7:0] tx_data;
  logic       tx_busy;

  // Load is decoded from state so the start bit follows one cycle after SEND_*; keeps inter-byte gaps short.
  always_comb begin
    tx_load = 1'b0;
    tx_data = word_buf_q[15:8];
    if (state_q == S_UT_SEND_HIGH) begin
      tx_load = !tx_busy;
    end else if (state_q == S_UT_SEND_LOW) begin
      tx_load = !tx_busy;
      tx_data = word_buf_q[7:0];
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_UT_IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
      sram_addr_q  <= '0;
      word_buf_q   <= '0;
      lat_q        <= '0;
      seen_rise_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (Initialize) begin
      state_q     <= S_UT_IDLE;
      lat_q       <= '0;
      seen_rise_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_UT_IDLE: begin
          done_q <= 1'b0;
          if (Enable) begin
            addr_q       <= Start_address;
            words_left_q <= Word_count;
            if (Word_count == '0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_UT_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_UT_ISSUE_READ;
            end
          end
        end
        S_UT_ISSUE_READ: begin
          sram_addr_q <= addr_q;
          lat_q       <= '0;
          state_q     <= S_UT_WAIT_READ;
        end
        S_UT_WAIT_READ: begin
          if (lat_q == LAT_LAST) begin
            word_buf_q <= SRAM_read_data;
            state_q    <= S_UT_SEND_HIGH;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        S_UT_SEND_HIGH: begin
          if (!tx_busy) begin
            seen_rise_q <= 1'b0;
            state_q     <= S_UT_WAIT_HIGH;
          end
        end
        S_UT_WAIT_HIGH: begin
          if (tx_busy) seen_rise_q <= 1'b1;
          else if (seen_rise_q) state_q <= S_UT_SEND_LOW;
        end
        S_UT_SEND_LOW: begin
          if (!tx_busy) begin
            seen_rise_q <= 1'b0;
            state_q     <= S_UT_WAIT_LOW;
          end
        end
        S_UT_WAIT_LOW: begin
          if (tx_busy) begin
            seen_rise_q <= 1'b1;
          end else if (seen_rise_q) begin
            words_left_q <= words_left_q - 18'd1;
            // Top of memory ends the block instead of wrapping the address back to 0.
            if (words_left_q == 18'd1 || addr_q == '1) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_UT_DONE;
            end else begin
              addr_q  <= addr_q + 18'd1;
              state_q <= S_UT_ISSUE_READ;
            end
          end
        end
        S_UT_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_UT_IDLE;
        end
        default: state_q <= S_UT_IDLE;
      endcase
    end
  end

  UART_transmit_controller #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .Clock_50  (Clock),
    .Resetn    (Resetn),
    .Initialize(Initialize),
    .Load      (tx_load),
    .TX_data   (tx_data),
    .Busy      (tx_busy),
    .UART_TX_O (UART_TX_O)
  );

  assign SRAM_address = sram_addr_q;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = busy_q;
  assign Done         = done_q;

endmodule
